// File: rtl/lc3b_types.sv
// Shared LC-3b types: the packed per-instruction control word, its width and NOP value, and the
// occupancy states of the generic pipeline register.
package lc3b_types;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] aluop;
    logic [1:0] pcmux_sel;
    logic [1:0] marmux_sel;
    logic       mdrmux_sel;
    logic [1:0] regfilemux_sel;
    logic [1:0] alumux_sel;
    logic       sr2mux_sel;
    logic [2:0] dest;
    logic       load_pc;
    logic       load_ir;
    logic       load_regfile;
    logic       load_mar;
    logic       load_mdr;
    logic       load_cc;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_byte_enable;
  } ctrl_struct;

  localparam int unsigned CTRL_W = $bits(ctrl_struct);

  // All-zero control word: no architectural state is loaded and memory stays idle.
  localparam ctrl_struct CTRL_NOP = '0;

  typedef enum logic [1:0] {
    ps_empty,
    ps_one,
    ps_two
  } pipe_state_e;

endpackage

// File: rtl/lc3b_pipe_entry.sv
// Load-enabled storage for one pipeline entry (control word plus data words).
module lc3b_pipe_entry #(
  parameter int unsigned W = 78
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) data_d = data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/lc3b_pipe_stage.sv
// Generic LC-3b inter-stage register: valid/ready handshake through a two-entry skid buffer,
// flush with bubble insertion and a saturating stall counter.
module lc3b_pipe_stage
  import lc3b_types::*;
#(
  parameter int unsigned CTRL_W   = lc3b_types::CTRL_W,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_DATA = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int unsigned DataBits = NUM_DATA * DATA_W;
  localparam int unsigned EntryW   = CTRL_W + DataBits;

  pipe_state_e       state_q, state_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [EntryW-1:0] main_q, main_d, skid_q, in_entry;
  logic              main_load, skid_load;
  logic              in_fire, out_fire;

  assign in_entry  = {in_ctrl, in_data};
  // Both handshake flags come from state only, so out_ready never reaches in_ready.
  assign out_valid = (state_q != ps_empty);
  assign in_ready  = (state_q != ps_two);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_entry;
    if (flush) begin
      state_d = ps_empty;
    end else begin
      unique case (state_q)
        ps_empty: begin
          if (in_fire) begin
            state_d   = ps_one;
            main_load = 1'b1;
          end
        end
        ps_one: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = ps_two;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = ps_empty;
          end
        end
        ps_two: begin
          if (out_fire) begin
            state_d   = ps_one;
            main_load = 1'b1;
            main_d    = skid_q;
          end
        end
        default: state_d = ps_empty;
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ps_empty;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end

  lc3b_pipe_entry #(
    .W(EntryW)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .load_i(main_load),
    .data_i(main_d),
    .data_o(main_q)
  );

  lc3b_pipe_entry #(
    .W(EntryW)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load_i(skid_load),
    .data_i(in_entry),
    .data_o(skid_q)
  );

  // Bubbles present an all-zero (NOP) control word so downstream stages stay inert.
  assign out_ctrl  = out_valid ? main_q[EntryW-1 -: CTRL_W] : '0;
  assign out_data  = out_valid ? main_q[DataBits-1:0] : '0;
  assign stall_cnt = stall_q;

  a_no_fire_in_two: assert property (@(posedge clk) disable iff (rst)
    !(in_fire && (state_q == ps_two)));

  a_nop_bubble: assert property (@(posedge clk) disable iff (rst)
    !out_valid |-> ((out_ctrl == '0) && (out_data == '0)));

  a_upstream_stable: assert property (@(posedge clk) disable iff (rst)
    (in_valid && !in_ready) |=> ($stable(in_ctrl) && $stable(in_data)))
    else $warning("upstream payload changed while the stage was not ready");

endmodule

// File: tb/tb_lc3b_pipe_stage.sv
// Scoreboard bench for lc3b_pipe_stage: the driver offers words, a monitor models occupancy,
// ordering, flush and the stall counter, and compares every output cycle.
module tb_lc3b_pipe_stage;

  localparam int unsigned CW = 30;
  localparam int unsigned DW = 16;
  localparam int unsigned ND = 3;
  localparam int unsigned SW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, flush, out_valid, out_ready;
  logic [CW-1:0]    in_ctrl, out_ctrl;
  logic [ND*DW-1:0] in_data, out_data;
  logic [SW-1:0]    stall_cnt;

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  logic [CW+ND*DW-1:0] exp_q[$];
  logic [SW-1:0]       stall_exp;
  logic                acc;
  logic [15:0]         w;

  always #5 clk = ~clk;

  lc3b_pipe_stage #(
    .CTRL_W  (CW),
    .DATA_W  (DW),
    .NUM_DATA(ND),
    .CNT_W   (SW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  function automatic logic [CW-1:0] mk_ctrl(input logic [15:0] v);
    return {~v[13:0], v};
  endfunction

  function automatic logic [ND*DW-1:0] mk_data(input logic [15:0] v);
    return {~v, v ^ 16'ha5a5, v};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic offer(input logic [15:0] v);
    in_ctrl = mk_ctrl(v);
    in_data = mk_data(v);
  endtask

  // From a falling edge: sample acceptance just before the rising edge, return on the next fall.
  task automatic tick();
    #4;
    acc = in_valid && in_ready;
    @(negedge clk);
  endtask

  // Monitor: samples one time unit before each rising edge.
  initial begin
    logic [CW+ND*DW-1:0] e;
    stall_exp = '0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_data", out_data, 0);
        exp_q.delete();
        stall_exp = '0;
      end else begin
        chk("out_valid", out_valid, exp_q.size() > 0);
        chk("in_ready", in_ready, exp_q.size() < 2);
        chk("stall_cnt", stall_cnt, stall_exp);
        if (!out_valid) begin
          chk("bubble_ctrl", out_ctrl, 0);
          chk("bubble_data", out_data, 0);
        end
        if (out_valid && !out_ready && stall_exp != 4'hf) stall_exp = stall_exp + 4'd1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", out_data, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_ctrl", out_ctrl, e[CW+ND*DW-1 -: CW]);
            chk("out_data", out_data, e[ND*DW-1:0]);
            pops++;
          end
        end
        if (flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back({in_ctrl, in_data});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    int p0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    acc       = 1'b0;
    offer(16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: full-throughput stream of ten words.
    p0 = pops;
    n = 0;
    w = 16'h1000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && n < 10; c++) begin
      offer(w);
      tick();
      if (acc) begin
        n++;
        w++;
        if (n == 1) chk("t1_valid_after_first", out_valid, 1);
      end
    end
    chk("t1_accepts", n, 10);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    chk("t1_outputs", pops - p0, 10);

    // 2: backpressure fills the skid entry.
    p0 = pops;
    n = 0;
    w = 16'h2000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      offer(w);
      tick();
      if (acc) begin
        n++;
        w++;
      end
    end
    chk("t2_in_ready_full", in_ready, 0);
    offer(w);
    for (int c = 0; c < 3; c++) tick();
    chk("t2_held_not_taken", acc, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && n < 3; c++) begin
      tick();
      if (acc) n++;
    end
    chk("t2_accepts", n, 3);
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    chk("t2_outputs", pops - p0, 3);

    // 3: flush while full with a word on offer.
    p0 = pops;
    n = 0;
    w = 16'h3000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      offer(w);
      tick();
      if (acc) begin
        n++;
        w++;
      end
    end
    offer(w);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t3_out_valid", out_valid, 0);
    chk("t3_out_ctrl", out_ctrl, 0);
    chk("t3_out_data", out_data, 0);
    chk("t3_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("t3_no_outputs", pops - p0, 0);

    // 4: stall counter saturation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    offer(16'h4000);
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    chk("t4_stall_sat", stall_cnt, 15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t4_stall_after_flush", stall_cnt, 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_stall_after_rst", stall_cnt, 0);

    // 5: asynchronous reset while full.
    n = 0;
    w = 16'h5000;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 10 && n < 2; c++) begin
      offer(w);
      tick();
      if (acc) begin
        n++;
        w++;
      end
    end
    offer(w);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("t5_async_out_valid", out_valid, 0);
    chk("t5_async_stall", stall_cnt, 0);
    chk("t5_async_ctrl", out_ctrl, 0);
    chk("t5_async_in_ready", in_ready, 1);
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    offer(16'h5100);
    acc = 1'b0;
    for (int c = 0; c < 5 && !acc; c++) tick();
    in_valid = 1'b0;
    chk("t5_first_valid", out_valid, 1);
    chk("t5_first_word", out_data[15:0], 16'h5100);
    tick();

    // 6: random handshake soak with occasional flush.
    w = 16'($urandom);
    offer(w);
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 99) < 5);
      tick();
      if (acc) begin
        w = 16'($urandom);
        offer(w);
      end
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    chk("t6_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_pipe_stage.md
Name: lc3b_pipe_stage

Overview:
- Generic, parametrised pipeline register between any two LC-3b stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one control word (the packed ctrl_struct) plus NUM_DATA data words.
- Uses a valid/ready handshake with a two-entry skid buffer, so in_ready is registered. Adds flush with bubble insertion and a saturating stall counter for performance debug.
- Replaces the hand-written per-stage load-enabled registers.

Parameters:
- CTRL_W, 30, width of the control word; matches ctrl_signal_length.
- DATA_W, 16, width of one data word; matches lc3b_word.
- NUM_DATA, 3, number of data words carried (e.g. pc, sr1 value, sr2/ir).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  stage can accept; driven from state only (no combinational path from out_ready).
- in_ctrl  input  CTRL_W  control word.
- in_data  input  NUM_DATA*DATA_W  data words; word k occupies bits [k*DATA_W +: DATA_W].
- flush  input  1  kill all held and incoming instructions (branch mispredict/trap).
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts.
- out_ctrl  output  CTRL_W  head control word; forced to all-zero (NOP) whenever out_valid=0.
- out_data  output  NUM_DATA*DATA_W  head data words; forced to zero when out_valid=0.
- stall_cnt  output  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Transfer definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (head) and skid entry, each holding ctrl plus data.
- State encoding (shared package): EMPTY, ONE, TWO.
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- Reset (async, rst=1):
  - state=EMPTY, both entries zeroed, stall_cnt=0.
  - Hence out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
  - Any handshake coinciding with rst is discarded.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE, in_fire & out_fire -> ONE, main<=in.
  - ONE, in_fire & !out_ready -> TWO, skid<=in.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> hold.
  - TWO: out_fire -> ONE, main<=skid; otherwise hold. in_fire is impossible in TWO (in_ready=0).
- Latency: data accepted at edge N is presented at out from cycle N+1. Zero bubbles at full throughput (ONE state, both sides firing every cycle).
- Ordering: strict FIFO; skid is never presented before main.
- Flush (highest priority):
  - Next state EMPTY; main and skid valid cleared.
  - Concurrent in_fire is dropped.
  - Concurrent out_fire still counts downstream (downstream is responsible for its own flush).
  - in_ready is 1 the cycle after flush.
- Bubble: when out_valid=0, out_ctrl=0 means load_pc=load_regfile=load_cc=mem_read=mem_write=0, i.e. a safe NOP.
- stall_cnt:
  - +1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Unaffected by flush; cleared only by rst.
- Reset mid-operation: held entries are lost; no partial output is produced.
- Assertions the implementation provides (non-synth):
  - in_fire never occurs in TWO.
  - out_ctrl == 0 whenever !out_valid.
  - Upstream stability: in_valid & !in_ready implies in_ctrl/in_data stable next cycle (warning only).

Decomposition:
- Shared package (lc3b_types) gains:
  - the pipe-state enum (ps_empty, ps_one, ps_two);
  - localparam CTRL_W tied to $bits(ctrl_struct);
  - a NOP constant ctrl_struct of all zeros.
- One sub-module: lc3b_pipe_entry, a single load-enabled, async-reset register of CTRL_W + NUM_DATA*DATA_W bits. Instantiated twice (main, skid).

Test Plan:
1. Reset then stream: assert rst, release; drive in_valid=1 with data words 0x1000..0x1009, out_ready=1 constantly -> out_valid rises 1 cycle after first accept; 10 outputs in order, one per cycle; in_ready never drops.
2. Backpressure/skid: stream 0x2000,0x2001,0x2002 with out_ready=0 from cycle 2 -> state reaches TWO, in_ready=0, 0x2002 held upstream; release out_ready -> outputs 0x2000,0x2001,0x2002 in order with no loss or duplication.
3. Flush in TWO with concurrent in_valid: flush=1 for one cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1; the word offered during flush never appears at output.
4. Stall counter saturation: CNT_W=4, hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reads 15 from cycle 15 onward; flush leaves it at 15; rst clears it to 0.
5. Async reset mid-stream: assert rst between clock edges while in TWO -> out_valid, stall_cnt and out_ctrl go to 0 immediately, without waiting for a clock edge; in_ready=1; after release the first accepted word is the first output.
6. Random handshake soak: 10k cycles of random in_valid/out_ready/flush (5% flush) -> scoreboard model matches every out_fire; NOP assertion never fires.
